divremsqrt_intpreproc_fsm: RTL and testbench
============================================

// Module: divremsqrt_intpreproc_fsm
// PURPOSE
//  Front end of the integer div/rem path on the shared FPU divider. Captures
//  operands, derives signs, magnitudes, leading-zero counts and special cases.
//  Normalizes dividend and divisor into the Q4.DIVb iteration format and runs
//  the iteration-count FSM. Drives the M-stage control/operand signals that
//  the div/rem/sqrt postprocessor consumes.
// PARAMETERS
//  P        none (cvw_t)  core config; uses XLEN, DIVb, INTDIVb, DIVBLEN, LOGR, DIVCOPIES
//  STEP     localparam    quotient bits per cycle = P.LOGR*P.DIVCOPIES
// PORTS
//  clk             in   1          clock
//  reset           in   1          synchronous, active-high reset
//  IntDivStartE    in   1          start request (integer div/rem op in E)
//  FlushE          in   1          kill in-flight operation
//  StallM          in   1          M stage stalled
//  ForwardedSrcAE  in   XLEN       dividend
//  ForwardedSrcBE  in   XLEN       divisor
//  SignedE         in   1          signed op (div/rem vs divu/remu)
//  RemOpE          in   1          1 = remainder, 0 = quotient
//  W64E            in   1          32-bit op on RV64 (ignored when XLEN=32)
//  XE, DE          out  DIVb+4     normalized |A|, |B|, Q4.DIVb
//  IterActiveE     out  1          datapath iterate enable
//  DivBusyE        out  1          stall request to hazard unit
//  DivDoneE        out  1          result ready for postproc
//  AM              out  XLEN       captured (extended) dividend
//  AsM, BsM        out  1          operand signs
//  RemOpM, W64M    out  1          captured op controls
//  ALTBM, BZeroM   out  1          |A|<|B|; B==0
//  SIGNOVERFLOWM   out  1          signed MIN / -1
//  SpecialCaseM    out  1          BZeroM|ALTBM|SIGNOVERFLOWM
//  IntNormShiftM   out  DIVBLEN    postproc normalization right-shift
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0. reset wins over every other input.
//  Operand prep (combinational on start): W64E=1 extends bits [31:0],
//   sign-extended if SignedE else zero-extended. As=SignedE&A[MSB]; Bs likewise.
//  |A|=As?-A:A (XLEN-bit; MIN stays MIN unsigned). LZA, LZB = leading zeros.
//  XE={3'b000,|A|<<LZA,0-pad}; DE same for |B|. Unsigned compare |A|<|B| -> ALTB.
//  mE=LZB-LZA+1; Cycles=max(1,ceil(mE/STEP)); IntNormShift=INTDIVb-Cycles*STEP.
//  FSM IDLE:  IntDivStartE&~FlushE -> register all M outputs (one cycle latency).
//    If special -> DONE, else -> BUSY with counter=Cycles-1.
//  BUSY: IterActiveE=DivBusyE=1; counter decrements each cycle.
//    At 0 -> DONE. FlushE -> IDLE, counter cleared.
//  DONE: DivDoneE=1, DivBusyE=0. Hold outputs while StallM; ~StallM -> IDLE.
//    FlushE in DONE has no effect.
//  Start while BUSY/DONE is ignored (hazard unit guarantees none).
//  Special case never asserts IterActiveE. DivDoneE is high exactly one
//   non-stalled cycle per op.
//  M outputs stable from capture until next accepted start.
// TESTING (XLEN=64, STEP=1 unless noted)
//  A=100,B=7 unsigned -> LZA=57,LZB=61,mE=5; BUSY 5 cycles; IntNormShiftM=INTDIVb-5.
//  B=0, A=42 -> BZeroM=1,SpecialCaseM=1; IDLE->DONE next cycle, IterActiveE never 1.
//  A=-7,B=2 signed -> AsM=1,BsM=0, XE encodes 7, ALTBM=0, BUSY 2 cycles.
//  A=3,B=10 -> ALTBM=1, DONE after 1 cycle. W64 A=0x80000000,B=0xFFFFFFFF signed -> SIGNOVERFLOWM=1.
//  FlushE in 2nd BUSY cycle -> IDLE next cycle, DivBusyE=0; new start then completes normally.
//  StallM held 3 cycles in DONE -> DivDoneE and M outputs held; reset mid-BUSY -> IDLE, outputs 0.

Source files
------------

// File: rtl/divremsqrt_intpreproc_fsm.sv
// divremsqrt_intpreproc_fsm: integer div/rem front end. Captures operands, derives
// signs/magnitudes/special cases, normalizes to Q4.DIVb and sequences iterations.
`default_nettype none

module divremsqrt_intpreproc_fsm #(
  parameter int XLEN      = 64,
  parameter int DIVb      = 64,
  parameter int INTDIVb   = 64,
  parameter int DIVBLEN   = 7,
  parameter int LOGR      = 1,
  parameter int DIVCOPIES = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               IntDivStartE,
  input  logic               FlushE,
  input  logic               StallM,
  input  logic [XLEN-1:0]    ForwardedSrcAE,
  input  logic [XLEN-1:0]    ForwardedSrcBE,
  input  logic               SignedE,
  input  logic               RemOpE,
  input  logic               W64E,
  output logic [DIVb+3:0]    XE,
  output logic [DIVb+3:0]    DE,
  output logic               IterActiveE,
  output logic               DivBusyE,
  output logic               DivDoneE,
  output logic [XLEN-1:0]    AM,
  output logic               AsM,
  output logic               BsM,
  output logic               RemOpM,
  output logic               W64M,
  output logic               ALTBM,
  output logic               BZeroM,
  output logic               SIGNOVERFLOWM,
  output logic               SpecialCaseM,
  output logic [DIVBLEN-1:0] IntNormShiftM
);

  localparam int STEP = LOGR * DIVCOPIES;
  localparam int CW   = DIVBLEN + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 capture;

  logic [XLEN-1:0]      a_ext, b_ext, mag_a, mag_b, norm_a, norm_b;
  logic                 w64_op, as_e, bs_e, altb_e, bzero_e, sov_e, special_e;
  logic [DIVBLEN-1:0]   lza, lzb, shift_e;
  logic signed [CW:0]   me;
  logic [CW-1:0]        cycles;

  logic [XLEN-1:0]      am_q;
  logic                 as_q, bs_q, remop_q, w64_q, altb_q, bzero_q, sov_q, special_q;
  logic [DIVBLEN-1:0]   shift_q;

  // 32-bit ops on RV64 use the low word, extended per signedness; MIN/-1 judged at op width.
  generate
    if (XLEN == 64) begin : g_rv64
      assign w64_op = W64E;
      assign a_ext  = W64E ? {{32{SignedE & ForwardedSrcAE[31]}}, ForwardedSrcAE[31:0]}
                           : ForwardedSrcAE;
      assign b_ext  = W64E ? {{32{SignedE & ForwardedSrcBE[31]}}, ForwardedSrcBE[31:0]}
                           : ForwardedSrcBE;
      assign sov_e  = SignedE & (W64E ? ((ForwardedSrcAE[31:0] == 32'h8000_0000) & (&ForwardedSrcBE[31:0]))
                                      : ((ForwardedSrcAE == {1'b1, {(XLEN-1){1'b0}}}) & (&ForwardedSrcBE)));
    end else begin : g_rv32
      assign w64_op = 1'b0;
      assign a_ext  = ForwardedSrcAE;
      assign b_ext  = ForwardedSrcBE;
      assign sov_e  = SignedE & (ForwardedSrcAE == {1'b1, {(XLEN-1){1'b0}}}) & (&ForwardedSrcBE);
    end
  endgenerate

  function automatic logic [DIVBLEN-1:0] lzc(input logic [XLEN-1:0] v);
    lzc = DIVBLEN'(XLEN);
    for (int i = 0; i < XLEN; i++)
      if (v[i]) lzc = DIVBLEN'(XLEN - 1 - i);
  endfunction

  assign as_e   = SignedE & a_ext[XLEN-1];
  assign bs_e   = SignedE & b_ext[XLEN-1];
  assign mag_a  = as_e ? -a_ext : a_ext;
  assign mag_b  = bs_e ? -b_ext : b_ext;
  assign lza    = lzc(mag_a);
  assign lzb    = lzc(mag_b);
  assign norm_a = mag_a << lza;
  assign norm_b = mag_b << lzb;
  assign XE     = reset ? '0 : {3'b000, norm_a, {(DIVb+1-XLEN){1'b0}}};
  assign DE     = reset ? '0 : {3'b000, norm_b, {(DIVb+1-XLEN){1'b0}}};

  assign altb_e    = mag_a < mag_b;
  assign bzero_e   = (b_ext == '0);
  assign special_e = bzero_e | altb_e | sov_e;

  always_comb begin
    me = $signed({2'b00, lzb}) - $signed({2'b00, lza}) + $signed((CW+1)'(1));
    if (me <= $signed((CW+1)'(1))) cycles = CW'(1);
    else                           cycles = CW'((CW'(me) + CW'(STEP - 1)) / CW'(STEP));
    shift_e = DIVBLEN'(INTDIVb) - DIVBLEN'(cycles * CW'(STEP));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      am_q      <= '0;
      as_q      <= 1'b0;
      bs_q      <= 1'b0;
      remop_q   <= 1'b0;
      w64_q     <= 1'b0;
      altb_q    <= 1'b0;
      bzero_q   <= 1'b0;
      sov_q     <= 1'b0;
      special_q <= 1'b0;
      shift_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (capture) begin
        am_q      <= a_ext;
        as_q      <= as_e;
        bs_q      <= bs_e;
        remop_q   <= RemOpE;
        w64_q     <= w64_op;
        altb_q    <= altb_e;
        bzero_q   <= bzero_e;
        sov_q     <= sov_e;
        special_q <= special_e;
        shift_q   <= shift_e;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    capture     = 1'b0;
    IterActiveE = 1'b0;
    DivBusyE    = 1'b0;
    DivDoneE    = 1'b0;
    case (state_q)
      IDLE: begin
        if (IntDivStartE & ~FlushE) begin
          capture = 1'b1;
          state_d = special_e ? DONE : BUSY;
          cnt_d   = special_e ? '0 : cycles - CW'(1);
        end
      end
      BUSY: begin
        IterActiveE = 1'b1;
        DivBusyE    = 1'b1;
        if (FlushE) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DONE: begin
        DivDoneE = 1'b1;
        if (~StallM) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign AM            = am_q;
  assign AsM           = as_q;
  assign BsM           = bs_q;
  assign RemOpM        = remop_q;
  assign W64M          = w64_q;
  assign ALTBM         = altb_q;
  assign BZeroM        = bzero_q;
  assign SIGNOVERFLOWM = sov_q;
  assign SpecialCaseM  = special_q;
  assign IntNormShiftM = shift_q;

endmodule

`default_nettype wire

// File: tb/tb_divremsqrt_intpreproc_fsm.sv
// Randomized bench for divremsqrt_intpreproc_fsm against an arithmetic reference model.
`default_nettype none

module tb_divremsqrt_intpreproc_fsm;
  localparam int XLEN = 64, DIVb = 64, INTDIVb = 64, DIVBLEN = 7, LOGR = 1, DIVCOPIES = 1;
  localparam int STEP = LOGR * DIVCOPIES;

  logic clk = 1'b0, reset = 1'b1;
  logic IntDivStartE = 0, FlushE = 0, StallM = 0, SignedE = 0, RemOpE = 0, W64E = 0;
  logic [XLEN-1:0] ForwardedSrcAE = '0, ForwardedSrcBE = '0;
  logic [DIVb+3:0] XE, DE;
  logic IterActiveE, DivBusyE, DivDoneE, AsM, BsM, RemOpM, W64M, ALTBM, BZeroM, SIGNOVERFLOWM, SpecialCaseM;
  logic [XLEN-1:0] AM;
  logic [DIVBLEN-1:0] IntNormShiftM;

  int n_checks = 0, n_errors = 0;

  divremsqrt_intpreproc_fsm #(.XLEN(XLEN), .DIVb(DIVb), .INTDIVb(INTDIVb), .DIVBLEN(DIVBLEN),
                              .LOGR(LOGR), .DIVCOPIES(DIVCOPIES)) dut (
    .clk(clk), .reset(reset), .IntDivStartE(IntDivStartE), .FlushE(FlushE), .StallM(StallM),
    .ForwardedSrcAE(ForwardedSrcAE), .ForwardedSrcBE(ForwardedSrcBE), .SignedE(SignedE),
    .RemOpE(RemOpE), .W64E(W64E), .XE(XE), .DE(DE), .IterActiveE(IterActiveE),
    .DivBusyE(DivBusyE), .DivDoneE(DivDoneE), .AM(AM), .AsM(AsM), .BsM(BsM), .RemOpM(RemOpM),
    .W64M(W64M), .ALTBM(ALTBM), .BZeroM(BZeroM), .SIGNOVERFLOWM(SIGNOVERFLOWM),
    .SpecialCaseM(SpecialCaseM), .IntNormShiftM(IntNormShiftM));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  typedef struct {
    logic [63:0] a_ext, b_ext;
    logic        as, bs, altb, bzero, sov, special;
    logic [67:0] x, d;
    int          cycles, shift;
  } exp_t;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic int lead_zeros(input logic [63:0] v);
    int n = 0;
    if (v == 0) return 64;
    while (!v[63]) begin v = v << 1; n++; end
    return n;
  endfunction

  function automatic exp_t model(input logic [63:0] a, input logic [63:0] b, input logic sg, input logic w64);
    exp_t e;
    logic [63:0] ma, mb;
    int lza, lzb, me;
    e.a_ext = w64 ? (sg ? 64'($signed(a[31:0])) : {32'd0, a[31:0]}) : a;
    e.b_ext = w64 ? (sg ? 64'($signed(b[31:0])) : {32'd0, b[31:0]}) : b;
    e.as = sg && e.a_ext[63];
    e.bs = sg && e.b_ext[63];
    ma = e.as ? (64'd0 - e.a_ext) : e.a_ext;
    mb = e.bs ? (64'd0 - e.b_ext) : e.b_ext;
    lza = lead_zeros(ma);
    lzb = lead_zeros(mb);
    e.x = {3'b000, 64'(ma << lza), 1'b0};
    e.d = {3'b000, 64'(mb << lzb), 1'b0};
    e.altb  = ma < mb;
    e.bzero = (e.b_ext == 0);
    if (w64) e.sov = sg && ($signed(a[31:0]) == -32'sd2147483648) && ($signed(b[31:0]) == -32'sd1);
    else     e.sov = sg && (a == 64'h8000_0000_0000_0000) && ($signed(b) == -64'sd1);
    e.special = e.bzero || e.altb || e.sov;
    me = lzb - lza + 1;
    e.cycles = (me <= 1) ? 1 : (me + STEP - 1) / STEP;
    e.shift  = INTDIVb - e.cycles * STEP;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk_m(input string tag, input exp_t e, input logic rem, input logic w64);
    chk({tag, "_AM"}, AM, e.a_ext);
    chk({tag, "_AsBs"}, {AsM, BsM}, {e.as, e.bs});
    chk({tag, "_ctl"}, {RemOpM, W64M}, {rem, w64});
    chk({tag, "_flags"}, {ALTBM, BZeroM, SIGNOVERFLOWM, SpecialCaseM}, {e.altb, e.bzero, e.sov, e.special});
    chk({tag, "_shift"}, IntNormShiftM, 7'(e.shift));
  endtask

  task automatic start_op(input logic [63:0] a, input logic [63:0] b, input logic sg,
                          input logic rem, input logic w64, output exp_t e);
    e = model(a, b, sg, w64);
    ForwardedSrcAE = a; ForwardedSrcBE = b; SignedE = sg; RemOpE = rem; W64E = w64;
    IntDivStartE = 1'b1;
    #1;
    chk("XE", XE, e.x);
    chk("DE", DE, e.d);
    chk("idle_busy", {IterActiveE, DivBusyE, DivDoneE}, 3'b000);
    tick();
    IntDivStartE = 1'b0;
    ForwardedSrcAE = {$urandom, $urandom}; ForwardedSrcBE = {$urandom, $urandom};
    SignedE = 1'($urandom); RemOpE = 1'($urandom); W64E = 1'($urandom);
  endtask

  task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic sg,
                        input logic rem, input logic w64, input int nstall);
    exp_t e;
    start_op(a, b, sg, rem, w64, e);
    if (!e.special)
      for (int i = 0; i < e.cycles; i++) begin
        chk("busy", {IterActiveE, DivBusyE, DivDoneE}, 3'b110);
        tick();
      end
    chk("done", {IterActiveE, DivBusyE, DivDoneE}, 3'b001);
    chk_m("m", e, rem, w64);
    StallM = (nstall > 0);
    for (int i = 0; i < nstall; i++) begin
      tick();
      chk("stall_done", {IterActiveE, DivBusyE, DivDoneE}, 3'b001);
      chk("stall_AM", AM, e.a_ext);
    end
    StallM = 1'b0;
    tick();
    chk("idle_after", {IterActiveE, DivBusyE, DivDoneE}, 3'b000);
    chk_m("held", e, rem, w64);
  endtask

  function automatic logic [63:0] rnd_op();
    logic [63:0] v;
    int kind = $urandom_range(0, 9);
    v = {$urandom, $urandom} >> $urandom_range(0, 63);
    if (kind == 0) v = 64'd0;
    else if (kind <= 2) v = 64'd0 - v;
    return v;
  endfunction

  initial begin
    exp_t e;
    repeat (3) tick();
    chk("rst_ctl", {IterActiveE, DivBusyE, DivDoneE}, 3'b000);
    chk("rst_AM", AM, 64'd0);
    chk("rst_flags", {AsM, BsM, RemOpM, W64M, ALTBM, BZeroM, SIGNOVERFLOWM, SpecialCaseM}, 8'd0);
    chk("rst_shift", IntNormShiftM, 7'd0);
    chk("rst_XE", XE, 68'd0);
    reset = 1'b0;
    tick();

    run_op(64'd100, 64'd7, 1'b0, 1'b0, 1'b0, 0);
    chk("tc_100_7_shift", IntNormShiftM, 7'(INTDIVb - 5));
    run_op(64'd42, 64'd0, 1'b0, 1'b1, 1'b0, 0);
    chk("tc_bzero", {BZeroM, SpecialCaseM}, 2'b11);
    run_op(-64'sd7, 64'd2, 1'b1, 1'b0, 1'b0, 0);
    run_op(64'd3, 64'd10, 1'b0, 1'b0, 1'b0, 0);
    chk("tc_altb", ALTBM, 1'b1);
    run_op(64'h8000_0000, 64'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, 0);
    chk("tc_sov32", SIGNOVERFLOWM, 1'b1);
    run_op(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0, 3);

    // Flush during the second BUSY cycle aborts; the next op runs normally.
    start_op(64'd100, 64'd7, 1'b0, 1'b0, 1'b0, e);
    tick();
    FlushE = 1'b1;
    tick();
    FlushE = 1'b0;
    chk("flush_idle", {IterActiveE, DivBusyE, DivDoneE}, 3'b000);
    run_op(64'd1000, 64'd3, 1'b0, 1'b0, 1'b0, 1);

    // Reset mid-BUSY returns to IDLE with cleared outputs.
    start_op(64'd1000, 64'd3, 1'b0, 1'b1, 1'b0, e);
    tick();
    reset = 1'b1;
    tick();
    chk("rstb_ctl", {IterActiveE, DivBusyE, DivDoneE}, 3'b000);
    chk("rstb_AM", AM, 64'd0);
    chk("rstb_flags", {RemOpM, SpecialCaseM, IntNormShiftM}, 9'd0);
    reset = 1'b0;
    tick();

    for (int k = 0; k < 60; k++) begin
      logic [63:0] a, b;
      logic sg, w64;
      a = rnd_op(); b = rnd_op();
      sg = 1'($urandom); w64 = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 15) == 0) begin
        sg = 1'b1;
        a = w64 ? 64'h8000_0000 : 64'h8000_0000_0000_0000;
        b = 64'hFFFF_FFFF_FFFF_FFFF;
      end
      run_op(a, b, sg, 1'($urandom), w64, $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
